// File: rtl/rom_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : rom_stream_reader
//  Purpose  : Reads a burst of consecutive words from a single-port ROM
//             (dist_mem / blk_mem) and presents them on a valid/ready stream.
//             It hides the ROM's fixed read latency, and a credit check keeps
//             the output FIFO from overflowing when the consumer stalls.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             start, base_addr,   - launch a burst of len words at base_addr
//             len
//             busy, done          - burst in progress / one-cycle completion
//             rom_addr, rom_en,   - registered ROM read port
//             rom_dout
//             m_data, m_valid,    - output stream
//             m_ready, m_last
//  Revision : 1.0 - initial release
// ============================================================================
module rom_stream_reader #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Parameter legality is checked at elaboration time.
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("rom_stream_reader: RD_LAT must be in 1..3");
  end
  if (FIFO_DEPTH < RD_LAT + 2) begin : g_bad_fifo_depth
    $error("rom_stream_reader: FIFO_DEPTH must be >= RD_LAT+2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q,    state_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                rom_en_q,   rom_en_d;
  logic [ADDR_W:0]     remain_q,   remain_d;   // reads still to be issued
  logic [ADDR_W:0]     len_q,      len_d;
  logic [ADDR_W:0]     beat_q,     beat_d;     // beats accepted so far
  logic [RD_LAT-1:0]   pipe_q,     pipe_d;     // one bit per read in flight
  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;

  logic                fifo_wr;
  logic                fifo_rd;
  logic                valid_w;
  logic                last_w;
  logic [CNT_W:0]      inflight_nxt;
  logic                credit_ok;

  assign valid_w = (fifo_cnt_q != '0);
  assign last_w  = valid_w && (beat_q == (len_q - (ADDR_W+1)'(1)));
  assign fifo_rd = valid_w && m_ready;
  // The read issued RD_LAT cycles ago is sampled at the end of this cycle.
  assign fifo_wr = pipe_q[RD_LAT-1];

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_en_d   = 1'b0;
    remain_d   = remain_q;
    len_d      = len_q;
    beat_d     = beat_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_mem_d = fifo_mem_q;

    pipe_d[0] = rom_en_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    if (fifo_wr) begin
      fifo_mem_d[wr_ptr_q] = rom_dout;
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (fifo_rd) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      beat_d   = beat_q + (ADDR_W+1)'(1);
    end
    fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);

    // rom_en is registered, so the issue decision for the next cycle uses the
    // occupancy that cycle will see: FIFO level after this cycle's write/pop
    // plus the reads that will still be in flight.
    inflight_nxt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_nxt = inflight_nxt + (CNT_W+1)'(pipe_d[i]);
    end
    credit_ok = (({1'b0, fifo_cnt_d} + inflight_nxt) < (CNT_W+1)'(FIFO_DEPTH));

    case (state_q)
      S_IDLE: begin
        // done_q marks the completion cycle, in which start is ignored.
        if (start && !done_q) begin
          len_d  = len;
          beat_d = '0;
          if (len != '0) begin
            state_d    = S_RUN;
            rom_en_d   = 1'b1;
            rom_addr_d = base_addr;
            remain_d   = len - (ADDR_W+1)'(1);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (remain_q == '0) begin
          // The final read is on the ROM port this cycle.
          state_d = S_DRAIN;
        end else if (credit_ok) begin
          rom_en_d   = 1'b1;
          rom_addr_d = rom_addr_q + ADDR_W'(1);
          remain_d   = remain_q - (ADDR_W+1)'(1);
        end
      end
      S_DRAIN: begin
        if (fifo_rd && last_w) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
      remain_q   <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      pipe_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rom_addr_q <= rom_addr_d;
      rom_en_q   <= rom_en_d;
      remain_q   <= remain_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      pipe_q     <= pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= fifo_mem_d[i];
      end
    end
  end

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_wr && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));

  assign busy     = busy_q;
  assign done     = done_q;
  assign rom_addr = rom_addr_q;
  assign rom_en   = rom_en_q;
  assign m_data   = fifo_mem_q[rd_ptr_q];
  assign m_valid  = valid_w;
  assign m_last   = last_w;

endmodule
`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_stream_reader
//  Purpose  : Self-checking bench for rom_stream_reader. Two instances run side
//             by side (RD_LAT=1 and RD_LAT=2, FIFO_DEPTH=4), each behind a ROM
//             model returning addr^8'h5A, checked cycle by cycle against a
//             transaction-level reference of the burst.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rom_stream_reader;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_s   [2];
  logic [7:0] base_s    [2];
  logic [8:0] len_s     [2];
  logic       m_ready_s [2];
  wire        busy_o    [2];
  wire        done_o    [2];
  wire        rom_en_o  [2];
  wire        m_valid_o [2];
  wire        m_last_o  [2];
  wire  [7:0] rom_addr_o[2];
  wire  [7:0] m_data_o  [2];
  wire  [7:0] rom_dout_i[2];

  // ROM models: latency 1 and latency 2.
  logic [7:0] rom0_q, rom1_a, rom1_b;
  always @(posedge clk) rom0_q <= rom_addr_o[0] ^ 8'h5A;
  always @(posedge clk) begin
    rom1_a <= rom_addr_o[1] ^ 8'h5A;
    rom1_b <= rom1_a;
  end
  assign rom_dout_i[0] = rom0_q;
  assign rom_dout_i[1] = rom1_b;

  rom_stream_reader #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .FIFO_DEPTH(DEPTH)) u_dut_l1 (
    .clk(clk), .rst(rst), .start(start_s[0]), .base_addr(base_s[0]), .len(len_s[0]),
    .busy(busy_o[0]), .done(done_o[0]), .rom_addr(rom_addr_o[0]), .rom_en(rom_en_o[0]),
    .rom_dout(rom_dout_i[0]), .m_data(m_data_o[0]), .m_valid(m_valid_o[0]),
    .m_ready(m_ready_s[0]), .m_last(m_last_o[0]));

  rom_stream_reader #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2), .FIFO_DEPTH(DEPTH)) u_dut_l2 (
    .clk(clk), .rst(rst), .start(start_s[1]), .base_addr(base_s[1]), .len(len_s[1]),
    .busy(busy_o[1]), .done(done_o[1]), .rom_addr(rom_addr_o[1]), .rom_en(rom_en_o[1]),
    .rom_dout(rom_dout_i[1]), .m_data(m_data_o[1]), .m_valid(m_valid_o[1]),
    .m_ready(m_ready_s[1]), .m_last(m_last_o[1]));

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference state per instance.
  bit act[2];
  int s0[2], mlen[2], mbase[2], niss[2], npop[2], done_at[2], last_addr[2];
  int icyc[2][512];

  // Requested stimulus for the next cycle.
  bit   st_req[2];
  int   base_req[2], len_req[2];
  int   rdy_mode;   // 0: ready held high, 1: random ready
  logic rst_req;

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d cyc%0d: observed=%0h expected=%0h", tag, k, cyc, obs, exp);
    end
  endtask

  function automatic int lat_of(int k);
    return k + 1;
  endfunction

  task automatic model_check(int k);
    bit was_act = act[k];
    int dn = done_at[k];
    bit en_exp, v_exp;
    en_exp = act[k] && (cyc >= s0[k] + 1) && (niss[k] < mlen[k]) && ((niss[k] - npop[k]) < DEPTH);
    chk("rom_en", k, rom_en_o[k], en_exp);
    if (en_exp) begin
      chk("rom_addr", k, rom_addr_o[k], (mbase[k] + niss[k]) & 255);
      last_addr[k] = (mbase[k] + niss[k]) & 255;
      icyc[k][niss[k]] = cyc;
      niss[k]++;
    end else begin
      chk("rom_addr_hold", k, rom_addr_o[k], last_addr[k]);
    end
    v_exp = act[k] && (npop[k] < niss[k]) && (icyc[k][npop[k]] + lat_of(k) + 1 <= cyc);
    chk("m_valid", k, m_valid_o[k], v_exp);
    if (v_exp) begin
      chk("m_data", k, m_data_o[k], ((mbase[k] + npop[k]) & 255) ^ 32'h5A);
      chk("m_last", k, m_last_o[k], (npop[k] == mlen[k] - 1));
      if (m_ready_s[k]) begin
        npop[k]++;
        if (npop[k] == mlen[k]) begin
          act[k] = 1'b0;
          done_at[k] = cyc + 1;
        end
      end
    end
    chk("done", k, done_o[k], (cyc == dn));
    if (was_act && cyc > s0[k]) chk("busy", k, busy_o[k], 1);
    else if (!was_act && cyc != dn) chk("busy", k, busy_o[k], 0);
    if (start_s[k] && !was_act && cyc != dn) begin
      s0[k] = cyc; mbase[k] = base_s[k]; mlen[k] = len_s[k];
      niss[k] = 0; npop[k] = 0;
      if (mlen[k] != 0) act[k] = 1'b1;
      else done_at[k] = cyc + 1;
    end
    if (rst) begin
      act[k] = 1'b0; done_at[k] = -10; last_addr[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rst = rst_req;
    for (int k = 0; k < 2; k++) begin
      start_s[k]   = st_req[k];
      base_s[k]    = base_req[k][7:0];
      len_s[k]     = len_req[k][8:0];
      m_ready_s[k] = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      st_req[k]    = 1'b0;
    end
    @(negedge clk);
    model_check(0);
    model_check(1);
  endtask

  task automatic launch(int b, int l);
    for (int k = 0; k < 2; k++) begin
      base_req[k] = b; len_req[k] = l; st_req[k] = 1'b1;
    end
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((act[0] || act[1] || cyc <= done_at[0] || cyc <= done_at[1]) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_in_budget", 0, 32'(act[0] | act[1]), 0);
    tick();
  endtask

  task automatic check_reset();
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, busy_o[k], 0);
      chk("rst_done", k, done_o[k], 0);
      chk("rst_rom_addr", k, rom_addr_o[k], 0);
      chk("rst_rom_en", k, rom_en_o[k], 0);
      chk("rst_m_data", k, m_data_o[k], 0);
      chk("rst_m_valid", k, m_valid_o[k], 0);
      chk("rst_m_last", k, m_last_o[k], 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst_req = 1'b1; rdy_mode = 0;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 0; base_s[k] = 0; len_s[k] = 0; m_ready_s[k] = 1;
      st_req[k] = 0; base_req[k] = 0; len_req[k] = 0;
      act[k] = 0; done_at[k] = -10; last_addr[k] = 0; s0[k] = 0;
      mlen[k] = 0; mbase[k] = 0; niss[k] = 0; npop[k] = 0;
    end
    repeat (2) @(posedge clk);
    tick();
    rst_req = 1'b0;
    tick();
    check_reset();
    repeat (2) tick();

    // T1: base 0x10, len 8, ready held high.
    launch(8'h10, 8); wait_idle(200);
    // T2: address wrap.
    launch(8'hFE, 4); wait_idle(200);
    // T3: len 16 with random backpressure.
    rdy_mode = 1; launch($urandom_range(0, 255), 16); wait_idle(400);
    // T4: empty burst, then full address space.
    rdy_mode = 0; launch(8'h33, 0); wait_idle(50);
    launch(8'h00, 256); wait_idle(1000);
    rdy_mode = 1; launch($urandom_range(0, 255), 256); wait_idle(3000);

    // T5: start re-pulsed with other arguments during the burst and on done.
    launch(8'h30, 12);
    tick();
    for (int n = 0; n < 500; n++) begin
      if (!act[0] && !act[1] && cyc >= done_at[0] && cyc >= done_at[1]) break;
      for (int k = 0; k < 2; k++) begin
        base_req[k] = $urandom_range(0, 255);
        len_req[k]  = $urandom_range(1, 255);
        if (act[k] || cyc + 1 == done_at[k]) st_req[k] = 1'b1;
      end
      tick();
    end
    wait_idle(50);

    // T6: reset in the middle of a len=10 burst.
    rdy_mode = 0; launch($urandom_range(0, 255), 10);
    for (int n = 0; n < 50 && npop[0] < 2; n++) tick();
    rst_req = 1'b1; tick();
    rst_req = 1'b0; tick();
    check_reset();
    repeat (8) tick();
    launch(8'h10, 8); wait_idle(200);

    // Extra random bursts.
    rdy_mode = 1;
    for (int r = 0; r < 6; r++) begin
      launch($urandom_range(0, 255), $urandom_range(1, 40));
      wait_idle(600);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
